// File: rtl/l2k_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : l2k_pkg
//  Purpose  : Shared definitions for the l2k walker and MMU: command codes,
//             walker states, descriptor valid bit and TLB entry layout.
//  Revision : 1.0 - initial release
// ============================================================================
package l2k_pkg;

   // MMU command codes
   localparam logic [1:0] CMD_WRITE = 2'd0;
   localparam logic [1:0] CMD_READ  = 2'd1;
   localparam logic [1:0] CMD_NONE  = 2'd3;

   // Bit of a PDE/PTE word that marks the descriptor as present
   localparam int PTE_VALID_BIT = 0;

   // Walker states
   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_PDE   = 3'd1,
      ST_PTE   = 3'd2,
      ST_FILL  = 3'd3,
      ST_FAULT = 3'd4
   } ptw_state_e;

   // TLB entry layout as seen by the MMU (64 bits, MSB first)
   typedef struct packed {
      logic        rsvd;
      logic [19:0] vpn;
      logic [10:0] asid;
      logic [31:0] pte;
   } tlb_entry_t;

   // Descriptor address: table base (4 KiB aligned) plus word index, no carry
   function automatic logic [31:0] walk_addr(input logic [19:0] base,
                                             input logic [9:0]  index);
      return {base, index, 2'b00};
   endfunction

endpackage
`default_nettype wire

// File: rtl/l2k_ptw.sv
`default_nettype none
// ============================================================================
//  Module   : l2k_ptw
//  Purpose  : Two-level hardware page-table walker. Accepts a TLB miss,
//             reads the PDE and PTE, then writes the TLB entry or reports a
//             fault.
//  Revision : 1.0 - initial release
// ============================================================================
module l2k_ptw
   import l2k_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        miss_valid,
   output logic        miss_ready,
   input  logic [31:0] miss_vaddr,
   input  logic [10:0] miss_asid,
   input  logic [31:0] pgdir,
   output logic        mem_req,
   output logic [31:0] mem_addr,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata,
   output logic [31:0] entry_addr_out,
   output logic [63:0] entry_out,
   output logic [1:0]  cmd,
   output logic        fault,
   output logic [31:0] fault_vaddr
);

   ptw_state_e  r_state;
   ptw_state_e  w_next_state;
   logic [31:0] r_vaddr;
   logic [10:0] r_asid;
   logic [19:0] r_pde_base;
   logic [31:0] r_pte;
   logic [31:0] r_fault_vaddr;
   logic        w_desc_valid;
   tlb_entry_t  w_entry;
   logic        w_unused_pgdir;

   assign w_desc_valid   = mem_rdata[PTE_VALID_BIT];
   assign fault_vaddr    = r_fault_vaddr;
   // Low pgdir bits are page offset and play no part in the walk
   assign w_unused_pgdir = ^pgdir[11:0];

   // State register; reset abandons any walk in progress
   always_ff @(posedge clk) begin
      if (!rst) r_state <= ST_IDLE;
      else      r_state <= w_next_state;
   end

   // Next-state logic; acks only matter while a read is outstanding
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         ST_IDLE:  if (miss_valid) w_next_state = ST_PDE;
         ST_PDE:   if (mem_ack) w_next_state = w_desc_valid ? ST_PTE  : ST_FAULT;
         ST_PTE:   if (mem_ack) w_next_state = w_desc_valid ? ST_FILL : ST_FAULT;
         ST_FILL:  w_next_state = ST_IDLE;
         ST_FAULT: w_next_state = ST_IDLE;
         default:  w_next_state = ST_IDLE;
      endcase
   end

   // Walk context: miss request, PDE base, PTE and last faulting address
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_vaddr       <= '0;
         r_asid        <= '0;
         r_pde_base    <= '0;
         r_pte         <= '0;
         r_fault_vaddr <= '0;
      end else begin
         if (r_state == ST_IDLE && miss_valid) begin
            r_vaddr <= miss_vaddr;
            r_asid  <= miss_asid;
         end
         if (r_state == ST_PDE && mem_ack && w_desc_valid)
            r_pde_base <= mem_rdata[31:12];
         if (r_state == ST_PTE && mem_ack && w_desc_valid)
            r_pte <= mem_rdata;
         if (w_next_state == ST_FAULT)
            r_fault_vaddr <= r_vaddr;
      end
   end

   // Entry assembled from the finished walk
   always_comb begin
      w_entry      = '0;
      w_entry.rsvd = 1'b0;
      w_entry.vpn  = r_vaddr[31:12];
      w_entry.asid = r_asid;
      w_entry.pte  = r_pte;
   end

   // Outputs decoded from the current state; pgdir is used live during PDE
   always_comb begin
      miss_ready     = 1'b0;
      mem_req        = 1'b0;
      mem_addr       = '0;
      cmd            = CMD_NONE;
      fault          = 1'b0;
      entry_out      = '0;
      entry_addr_out = '0;
      case (r_state)
         ST_IDLE:  miss_ready = 1'b1;
         ST_PDE: begin
            mem_req  = 1'b1;
            mem_addr = walk_addr(pgdir[31:12], r_vaddr[31:22]);
         end
         ST_PTE: begin
            mem_req  = 1'b1;
            mem_addr = walk_addr(r_pde_base, r_vaddr[21:12]);
         end
         ST_FILL: begin
            cmd            = CMD_WRITE;
            entry_addr_out = r_vaddr;
            entry_out      = w_entry;
         end
         ST_FAULT: fault = 1'b1;
         default: ;
      endcase
   end

endmodule
`default_nettype wire

// File: tb/tb_l2k_ptw.sv
`default_nettype none
// ============================================================================
//  Module   : tb_l2k_ptw
//  Purpose  : Self-checking bench for l2k_ptw: directed walks with literal
//             expectations, then randomized misses, memory latency, spurious
//             acks, pgdir changes and resets against a walk-level model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_l2k_ptw;

   logic        clk = 1'b0;
   logic        rst;
   logic        miss_valid;
   logic        miss_ready;
   logic [31:0] miss_vaddr;
   logic [10:0] miss_asid;
   logic [31:0] pgdir;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_ack;
   logic [31:0] mem_rdata;
   logic [31:0] entry_addr_out;
   logic [63:0] entry_out;
   logic [1:0]  cmd;
   logic        fault;
   logic [31:0] fault_vaddr;

   always #5 clk = ~clk;

   l2k_ptw dut (
      .clk(clk), .rst(rst),
      .miss_valid(miss_valid), .miss_ready(miss_ready),
      .miss_vaddr(miss_vaddr), .miss_asid(miss_asid), .pgdir(pgdir),
      .mem_req(mem_req), .mem_addr(mem_addr),
      .mem_ack(mem_ack), .mem_rdata(mem_rdata),
      .entry_addr_out(entry_addr_out), .entry_out(entry_out),
      .cmd(cmd), .fault(fault), .fault_vaddr(fault_vaddr)
   );

   // Scripted memory responses (written by the driver, consumed by memory)
   int          dly_tab [32];
   logic [31:0] dat_tab [32];
   int          dly_wr = 0;
   int          dat_wr = 0;
   int          inject_req = 0;
   logic [31:0] inject_data = '0;
   bit          noise_en = 1'b0;

   // Memory: per-request latency, scripted or random data, stray acks
   initial begin
      int          dly_rd, dat_rd, inject_done, cnt, dly;
      bit          busy;
      logic [31:0] t;
      dly_rd = 0; dat_rd = 0; inject_done = 0; cnt = 0; dly = 0; busy = 1'b0;
      mem_ack = 1'b0; mem_rdata = '0;
      forever begin
         @(posedge clk); #1;
         mem_ack = 1'b0;
         if (mem_req) begin
            if (!busy) begin
               busy = 1'b1; cnt = 0;
               if (dly_rd < dly_wr) begin dly = dly_tab[dly_rd]; dly_rd++; end
               else dly = int'($urandom_range(0, 3));
            end
            if (cnt == dly) begin
               mem_ack = 1'b1; busy = 1'b0;
               if (dat_rd < dat_wr) begin mem_rdata = dat_tab[dat_rd]; dat_rd++; end
               else begin
                  t = $urandom;
                  t[0] = ($urandom_range(0, 7) != 0);
                  mem_rdata = t;
               end
            end else begin
               cnt++;
               mem_rdata = $urandom;
            end
         end else begin
            busy = 1'b0;
            if (inject_done != inject_req) begin
               inject_done++;
               mem_ack = 1'b1; mem_rdata = inject_data;
            end else if (noise_en && $urandom_range(0, 5) == 0) begin
               mem_ack = 1'b1; mem_rdata = $urandom | 32'h1;
            end else mem_rdata = $urandom;
         end
      end
   end

   // Walk-level model: which descriptor (if any) is being fetched
   bit          m_busy;
   int          m_level;     // descriptors fetched successfully so far
   bit          m_bad;       // last fetch returned a non-present descriptor
   logic [31:0] m_va, m_pde, m_pte, m_fva;
   logic [10:0] m_asid;
   int          n_checks = 0;
   int          n_fail = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: actual=%h required=%h", name, $time, act, exp);
      end
   endtask

   // Compare all outputs against the model, then advance it with this cycle's inputs
   task automatic model_step();
      bit          reading, filling, faulting;
      logic [31:0] base;
      logic [9:0]  idx;
      reading  = m_busy && !m_bad && (m_level < 2);
      filling  = m_busy && !m_bad && (m_level == 2);
      faulting = m_busy && m_bad;
      check("miss_ready", 64'(miss_ready), 64'(!m_busy));
      check("mem_req", 64'(mem_req), 64'(reading));
      if (reading) begin
         base = (m_level == 0) ? pgdir : m_pde;
         idx  = (m_level == 0) ? m_va[31:22] : m_va[21:12];
         check("mem_addr", 64'(mem_addr), 64'({base[31:12], idx, 2'b00}));
      end
      check("cmd", 64'(cmd), 64'(filling ? 2'd0 : 2'd3));
      check("fault", 64'(fault), 64'(faulting));
      check("fault_vaddr", 64'(fault_vaddr), 64'(m_fva));
      if (filling) begin
         check("entry_out", entry_out, {1'b0, m_va[31:12], m_asid, m_pte});
         check("entry_addr_out", 64'(entry_addr_out), 64'(m_va));
      end
      if (!rst) begin
         m_busy = 1'b0; m_fva = '0;
      end else if (!m_busy) begin
         if (miss_valid) begin
            m_busy = 1'b1; m_level = 0; m_bad = 1'b0;
            m_va = miss_vaddr; m_asid = miss_asid;
         end
      end else if (filling || faulting) begin
         m_busy = 1'b0;
      end else if (mem_ack) begin
         if (mem_rdata[0]) begin
            if (m_level == 0) m_pde = mem_rdata; else m_pte = mem_rdata;
            m_level++;
         end else begin
            m_bad = 1'b1; m_fva = m_va;
         end
      end
   endtask

   task automatic at_neg(); @(negedge clk); model_step(); endtask
   task automatic to_pos(); @(posedge clk); #1; endtask
   task automatic idle_cycles(input int n);
      repeat (n) begin at_neg(); to_pos(); end
   endtask
   task automatic push_dly(input int d); dly_tab[dly_wr] = d; dly_wr++; endtask
   task automatic push_dat(input logic [31:0] d); dat_tab[dat_wr] = d; dat_wr++; endtask
   task automatic wander_pgdir();
      if (noise_en && $urandom_range(0, 3) == 0) pgdir = $urandom;
   endtask

   // Start a walk from IDLE and tally output activity over n cycles
   task automatic run_walk(input logic [31:0] va, input logic [10:0] asid, input int n,
                           output int reqs, output int faults, output int writes);
      reqs = 0; faults = 0; writes = 0;
      miss_valid = 1'b1; miss_vaddr = va; miss_asid = asid;
      at_neg(); to_pos();
      miss_valid = 1'b0;
      repeat (n) begin
         at_neg();
         if (mem_req) reqs++;
         if (fault) faults++;
         if (cmd == 2'd0) writes++;
         to_pos();
      end
   endtask

   // Present a miss and hold it until the walker takes it
   task automatic issue_miss(input logic [31:0] va, input logic [10:0] asid);
      bit taken;
      taken = 1'b0;
      miss_valid = 1'b1; miss_vaddr = va; miss_asid = asid;
      for (int i = 0; i < 100 && !taken; i++) begin
         at_neg();
         if (miss_ready && rst) taken = 1'b1;
         to_pos();
         wander_pgdir();
      end
      miss_valid = 1'b0;
      if (!taken) check("accept_timeout", 64'(taken), 64'(1'b1));
   endtask

   initial begin
      int          reqs, faults, writes, r;
      logic [31:0] va;
      rst = 1'b0; miss_valid = 1'b0; miss_vaddr = '0; miss_asid = '0;
      pgdir = 32'h00010000;
      m_busy = 1'b0; m_level = 0; m_bad = 1'b0;
      m_va = '0; m_pde = '0; m_pte = '0; m_fva = '0; m_asid = '0;

      // Reset values
      at_neg();
      check("rst_miss_ready", 64'(miss_ready), 64'(1'b1));
      check("rst_mem_req", 64'(mem_req), 64'(1'b0));
      check("rst_cmd", 64'(cmd), 64'(2'd3));
      check("rst_fault", 64'(fault), 64'(1'b0));
      check("rst_mem_addr", 64'(mem_addr), 64'(32'h0));
      check("rst_entry_out", entry_out, 64'h0);
      check("rst_entry_addr", 64'(entry_addr_out), 64'(32'h0));
      check("rst_fault_vaddr", 64'(fault_vaddr), 64'(32'h0));
      to_pos();
      rst = 1'b1;

      // Normal zero-wait walk with literal addresses and entry
      push_dly(0); push_dat(32'h00020001);
      push_dly(0); push_dat(32'h12345003);
      miss_valid = 1'b1; miss_vaddr = 32'h00403ABC; miss_asid = 11'd5;
      at_neg();
      check("t1_c0_ready", 64'(miss_ready), 64'(1'b1));
      to_pos(); miss_valid = 1'b0;
      at_neg();
      check("t1_c1_req", 64'(mem_req), 64'(1'b1));
      check("t1_c1_pde_addr", 64'(mem_addr), 64'(32'h00010004));
      to_pos(); at_neg();
      check("t1_c2_pte_addr", 64'(mem_addr), 64'(32'h0002000C));
      to_pos(); at_neg();
      check("t1_c3_cmd", 64'(cmd), 64'(2'd0));
      check("t1_c3_entry", entry_out, {1'b0, 20'h00403, 11'd5, 32'h12345003});
      check("t1_c3_entry_addr", 64'(entry_addr_out), 64'(32'h00403ABC));
      to_pos(); at_neg();
      check("t1_c4_ready", 64'(miss_ready), 64'(1'b1));
      to_pos();

      // PDE not present
      push_dly(0); push_dat(32'h00020000);
      run_walk(32'h87654321, 11'd2, 6, reqs, faults, writes);
      check("t2_req_cycles", 64'(reqs), 64'(1));
      check("t2_fault_cycles", 64'(faults), 64'(1));
      check("t2_writes", 64'(writes), 64'(0));
      check("t2_fault_vaddr", 64'(fault_vaddr), 64'(32'h87654321));

      // PTE not present, five wait states per read
      push_dly(5); push_dat(32'h00020001);
      push_dly(5); push_dat(32'h00000000);
      run_walk(32'h00403ABC, 11'd9, 20, reqs, faults, writes);
      check("t3_req_cycles", 64'(reqs), 64'(12));
      check("t3_fault_cycles", 64'(faults), 64'(1));
      check("t3_writes", 64'(writes), 64'(0));
      check("t3_fault_vaddr", 64'(fault_vaddr), 64'(32'h00403ABC));

      // Reset during PTE, then a late ack while idle
      push_dly(0); push_dat(32'h00020001);
      push_dly(10);
      miss_valid = 1'b1; miss_vaddr = 32'h00403ABC; miss_asid = 11'd3;
      at_neg(); to_pos(); miss_valid = 1'b0;
      at_neg(); to_pos();
      at_neg();
      check("t4_in_pte", 64'(mem_req), 64'(1'b1));
      to_pos(); at_neg(); to_pos();
      rst = 1'b0;
      at_neg(); to_pos();
      rst = 1'b1;
      at_neg();
      check("t4_ready_after_rst", 64'(miss_ready), 64'(1'b1));
      check("t4_fva_cleared", 64'(fault_vaddr), 64'(32'h0));
      inject_data = 32'h12345003; inject_req++;
      to_pos();
      writes = 0; faults = 0;
      repeat (6) begin
         at_neg();
         if (cmd == 2'd0) writes++;
         if (fault) faults++;
         to_pos();
      end
      check("t4_no_write", 64'(writes), 64'(0));
      check("t4_no_fault", 64'(faults), 64'(0));
      check("t4_ready_end", 64'(miss_ready), 64'(1'b1));

      // Reset wins over a simultaneous miss
      rst = 1'b0; miss_valid = 1'b1; miss_vaddr = 32'h00403ABC; miss_asid = 11'd4;
      at_neg(); to_pos();
      rst = 1'b1; miss_valid = 1'b0;
      at_neg();
      check("t5_no_walk", 64'(mem_req), 64'(1'b0));
      check("t5_ready", 64'(miss_ready), 64'(1'b1));
      to_pos();

      // Held second miss, then the all-ones boundary address
      push_dly(0); push_dat(32'h00020001);
      push_dly(0); push_dat(32'h11111003);
      push_dly(0); push_dat(32'h00ABC001);
      push_dly(0); push_dat(32'h22222003);
      miss_valid = 1'b1; miss_vaddr = 32'h00403ABC; miss_asid = 11'd1;
      at_neg(); to_pos();
      miss_vaddr = 32'hFFFFF000; miss_asid = 11'd7;
      at_neg();
      check("t6_held", 64'(miss_ready), 64'(1'b0));
      to_pos(); at_neg(); to_pos(); at_neg();
      check("t6_first_fill", 64'(entry_addr_out), 64'(32'h00403ABC));
      to_pos(); at_neg();
      check("t6_second_ready", 64'(miss_ready), 64'(1'b1));
      to_pos(); miss_valid = 1'b0;
      at_neg();
      check("t6_boundary_pde", 64'(mem_addr), 64'(32'h00010FFC));
      to_pos(); at_neg();
      check("t6_boundary_pte", 64'(mem_addr), 64'(32'h00ABCFFC));
      to_pos(); at_neg();
      check("t6_boundary_entry", entry_out, {1'b0, 20'hFFFFF, 11'd7, 32'h22222003});
      check("t6_boundary_entry_addr", 64'(entry_addr_out), 64'(32'hFFFFF000));
      to_pos();

      // Randomized traffic
      noise_en = 1'b1;
      for (int it = 0; it < 160; it++) begin
         r = int'($urandom_range(0, 15));
         if (r == 0) begin
            rst = 1'b0; miss_valid = 1'($urandom_range(0, 1));
            miss_vaddr = $urandom; miss_asid = 11'($urandom);
            idle_cycles(int'($urandom_range(1, 2)));
            rst = 1'b1; miss_valid = 1'b0;
         end else begin
            va = ($urandom_range(0, 7) == 0) ? 32'hFFFFF000 : $urandom;
            issue_miss(va, 11'($urandom));
            idle_cycles(int'($urandom_range(0, 3)));
         end
      end
      idle_cycles(20);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/l2k_ptw.md
L2K_PTW -- requirements
Module: l2k_ptw

Interface
REQ-001 The module SHALL have one clock and a synchronous, active-low reset; the ports SHALL be as follows.
REQ-002 clk  in  1  clock; all state changes on rising edge.
REQ-003 rst  in  1  synchronous, active-low reset.
REQ-004 miss_valid  in  1  TLB miss request.
REQ-005 miss_ready  out  1  walker can accept a miss.
REQ-006 miss_vaddr  in  32  faulting virtual address.
REQ-007 miss_asid  in  11  address-space ID of the miss.
REQ-008 pgdir  in  32  page-directory physical base; bits [11:0] ignored.
REQ-009 mem_req  out  1  memory read request.
REQ-010 mem_addr  out  32  word-aligned physical read address.
REQ-011 mem_ack  in  1  read-data-valid strobe.
REQ-012 mem_rdata  in  32  read data, valid when mem_ack=1.
REQ-013 entry_addr_out  out  32  TLB index source (vaddr); the MMU uses bits [17:12].
REQ-014 entry_out  out  64  TLB entry for the MMU.
REQ-015 cmd  out  2  MMU command: CMD_WRITE=0, CMD_READ=1, CMD_NONE=3.
REQ-016 fault  out  1  one-cycle pulse: walk failed.
REQ-017 fault_vaddr  out  32  vaddr of the last fault, held until the next fault.

Function
REQ-018 The state machine SHALL have the states IDLE, PDE, PTE, FILL and FAULT.
REQ-019 miss_ready SHALL be 1 only in IDLE; a miss SHALL be accepted when miss_valid & miss_ready, and miss_vaddr/miss_asid SHALL be latched. The next state SHALL be PDE.
REQ-020 In PDE, mem_req SHALL be 1 and mem_addr SHALL be {pgdir[31:12], vaddr[31:22], 2'b00}.
REQ-021 In PTE, mem_req SHALL be 1 and mem_addr SHALL be {pde[31:12], vaddr[21:12], 2'b00}.
REQ-022 mem_req SHALL stay high through the mem_ack cycle and drop on the next cycle. mem_ack SHALL be honoured in the same cycle mem_req rises.
REQ-023 mem_ack SHALL be ignored in IDLE, FILL and FAULT.
REQ-024 On the PDE ack: if rdata[0]=0, the next state SHALL be FAULT; otherwise the walker SHALL latch the PDE and go to PTE.
REQ-025 On the PTE ack: if rdata[0]=0, the next state SHALL be FAULT; otherwise the walker SHALL latch the PTE and go to FILL.
REQ-026 FILL SHALL last exactly 1 cycle, with:
- cmd=CMD_WRITE
- entry_addr_out=vaddr
- entry_out={1'b0, vaddr[31:12], asid, pte}
- next state IDLE.
REQ-027 FAULT SHALL last exactly 1 cycle, with fault=1 and fault_vaddr updated; the next state SHALL be IDLE and no TLB write SHALL occur.
REQ-028 cmd SHALL be CMD_NONE in every state except FILL; the module SHALL never emit CMD_READ.
REQ-029 The minimum latency with zero-wait acks SHALL be: accept at cycle 0, FILL at cycle 3, miss_ready again at cycle 4.
REQ-030 Address arithmetic SHALL be pure concatenation, with no carry or wrap. vaddr 0xFFFFF000 SHALL index PDE 1023 and PTE 1023.
REQ-031 A miss_valid asserted outside IDLE SHALL be held off by miss_ready=0 and not dropped.
REQ-032 pgdir SHALL be sampled during PDE, so a change mid-walk after the PDE ack SHALL have no effect.

Reset
REQ-033 While rst=0 at a clock edge, the walker SHALL enter IDLE and set:
- mem_req=0, cmd=CMD_NONE, fault=0, miss_ready=1 on the following cycle
- fault_vaddr=0, entry_out=0, entry_addr_out=0, mem_addr=0.
REQ-034 Reset mid-walk SHALL abandon the walk with no TLB write and no fault; a late mem_ack after reset SHALL be ignored.
REQ-035 Reset SHALL take priority over a simultaneous miss_valid.

Structure
REQ-036 The CMD_* constants, the state enum, the PTE/PDE valid-bit position and the entry-field layout SHALL live in the shared package l2k_pkg, also used by l2k_mmu.
REQ-037 The walker SHALL be a single module with no sub-module; the FSM, latches and address muxing SHALL be in one file.

Verification
REQ-038 Normal walk: pgdir=0x00010000, vaddr=0x00403ABC, asid=5, zero-wait acks. Responses:
- mem_addr=0x00010004, then PDE rdata 0x00020001.
- mem_addr=0x0002000C, then PTE rdata 0x12345003.
- At cycle 3: cmd=0, entry_out={0, 0x00403, 5, 0x12345003}, entry_addr_out=0x00403ABC.
REQ-039 PDE fault: PDE rdata=0x00020000 -> fault=1 for 1 cycle, fault_vaddr=vaddr, no second mem_req, cmd never 0.
REQ-040 PTE fault with wait states: acks delayed 5 cycles, PTE rdata=0x0 -> mem_req stays high 6 cycles per read, then a fault pulse.
REQ-041 Reset mid-walk: rst=0 during PTE, then mem_ack arrives in IDLE -> no cmd write, no fault, miss_ready=1.
REQ-042 Back-to-back: a second miss held during a walk -> accepted the cycle after FILL returns to IDLE, using its own vaddr; boundary vaddr 0xFFFFF000 -> mem_addr={pgdir[31:12], 0xFFC}.
